uart_tx_fifo: RTL

- Buffered feeder that sits directly upstream of the UART transmitter.
- Accepts 9-bit words from the ATC message logic at up to one per clock and stores them in a circular FIFO.
- Issues them to the transmitter one at a time using its send/ready handshake, guarding against the single-cycle ready pulse that the transmitter raises while it finishes a stop bit.
- Reports fill level, sticky overflow, and sticky lost-word status.

---
 rtl/uart_tx_fifo.sv | 127 ++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular FIFO feeding a UART transmitter one word at a time.
//
// Ports:
//   clock, reset        system clock; asynchronous active-high reset
//   wr_en, wr_data      producer write strobe and word
//   full, empty, count  occupancy status, all derived from the registered count
//   clear_status        clears the sticky overflow and lost flags
//   overflow            sticky: a write was dropped because the FIFO was full
//   lost                sticky: a launched word was not accepted by the transmitter
//   tx_send, tx_data    one-cycle launch pulse and its word
//   tx_ready            transmitter ready
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 9,
  localparam int unsigned CntW = $clog2(DEPTH + 1),
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count,
  input  logic             clear_status,
  output logic             overflow,
  output logic             lost,
  output logic             tx_send,
  output logic [WIDTH-1:0] tx_data,
  input  logic             tx_ready
);

  typedef enum logic [1:0] {StIdle, StSend, StBusy} state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        count_q, count_d;
  logic                   ready_q;
  logic                   overflow_q, overflow_d;
  logic                   lost_q, lost_d;
  logic                   tx_send_q, tx_send_d;
  logic [WIDTH-1:0]       tx_data_q, tx_data_d;
  logic                   push, pop;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  // Full is sampled from the registered count, so a pop in the same cycle
  // never makes room for a write into a full FIFO.
  assign push = wr_en & ~full;
  assign pop  = (state_q == StSend);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Set wins over clear when both happen in one cycle.
  always_comb begin
    overflow_d = (wr_en & full) | (overflow_q & ~clear_status);
    lost_d     = ((state_q == StBusy) & tx_ready) | (lost_q & ~clear_status);
  end

  // Launch only after two consecutive ready cycles: a lone ready pulse is the
  // transmitter finishing a stop bit, not a truly idle transmitter.
  always_comb begin
    state_d   = state_q;
    tx_send_d = 1'b0;
    tx_data_d = tx_data_q;
    unique case (state_q)
      StIdle: begin
        if (!empty && tx_ready && ready_q) begin
          state_d   = StSend;
          tx_send_d = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
        end
      end
      StSend:  state_d = StBusy;
      StBusy:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
      lost_q     <= 1'b0;
      tx_send_q  <= 1'b0;
      tx_data_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ready_q    <= tx_ready;
      overflow_q <= overflow_d;
      lost_q     <= lost_d;
      tx_send_q  <= tx_send_d;
      tx_data_q  <= tx_data_d;
      if (push) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign lost     = lost_q;
  assign tx_send  = tx_send_q;
  assign tx_data  = tx_data_q;

endmodule
